intpol2_nch_core: RTL

INTPOL2_NCH_CORE -- requirements
Module: intpol2_nch_core

---
 rtl/intpol2_nch_core.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/intpol2_nch_core.sv
`default_nettype none
// ============================================================================
// Module   : intpol2_nch_core
// Purpose  : N-channel second-order (3-tap) interpolator. A shared phase
//            accumulator walks a Q0.M_bits position across a sliding window
//            M0/M1/M2 of input samples and evaluates a quadratic through the
//            window for every output beat. All channels share one controller.
// Options  : define INTPOL2_NCH_SAT_EN to saturate each channel output to the
//            sample range; otherwise outputs wrap to DATAPATH_WIDTH bits.
// Revision : 1.0 - initial release
// ============================================================================
module intpol2_nch_core #(
  parameter int DATAPATH_WIDTH = 12,
  parameter int M_bits         = 11,
  parameter int N_CH           = 2,
  parameter int CONFIG_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [4*CONFIG_WIDTH-1:0]      config_reg,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [N_CH*DATAPATH_WIDTH-1:0] s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [N_CH*DATAPATH_WIDTH-1:0] m_data,
  output logic [7:0]                     status_reg
);

  localparam int c_DW = DATAPATH_WIDTH;
  // Polynomial coefficients are carried at three bits above the sample width.
  localparam int c_IW = DATAPATH_WIDTH + 3;
  // Working width for the Horner products; comfortably covers x*coefficient.
  localparam int c_WW = DATAPATH_WIDTH + M_bits + 8;

  localparam logic [M_bits:0]         c_STEP_FULL = {1'b1, {M_bits{1'b0}}};
  localparam logic [CONFIG_WIDTH-1:0] c_CNT_ONE   = {{(CONFIG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [c_WW-1:0]  c_Y_MAX     = {{(c_WW-c_DW+1){1'b0}}, {(c_DW-1){1'b1}}};
  localparam logic signed [c_WW-1:0]  c_Y_MIN     = ~c_Y_MAX;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                         r_state;
  logic [M_bits:0]                r_step;
  logic [CONFIG_WIDTH-1:0]        r_ilen;
  logic [CONFIG_WIDTH-1:0]        r_load_cnt;
  logic [CONFIG_WIDTH-1:0]        r_out_cnt;
  logic [M_bits-1:0]              r_x;
  logic [1:0]                     r_fill_cnt;
  logic                           r_m_valid;
  logic [N_CH*c_DW-1:0]           r_m_data;
  logic signed [c_DW-1:0]         r_m0 [N_CH];
  logic signed [c_DW-1:0]         r_m1 [N_CH];
  logic signed [c_DW-1:0]         r_m2 [N_CH];

  logic signed [c_DW-1:0]         w_s_ch [N_CH];
  logic [N_CH*c_DW-1:0]           w_y;
  logic                           w_cfg_bypass;
  logic [M_bits:0]                w_cfg_step;
  logic [CONFIG_WIDTH-1:0]        w_cfg_ilen;
  logic                           w_bypass;
  logic                           w_m_fire;
  logic                           w_out_room;
  logic                           w_more;
  logic                           w_done_hit;
  logic                           w_last_load;
  logic                           w_load;
  logic [M_bits+1:0]              w_x_sum;
  logic                           w_carry;
  logic                           w_unused_cfg;

  // Quadratic through (0,m0),(1,m1),(2,m2) evaluated at fractional x.
  function automatic logic signed [c_DW-1:0] f_interp(
    input logic signed [c_DW-1:0] m0,
    input logic signed [c_DW-1:0] m1,
    input logic signed [c_DW-1:0] m2,
    input logic [M_bits-1:0]      x
  );
    logic signed [c_WW-1:0] a0, a1, a2, xs, p1, p2, acc;
    logic signed [c_IW-1:0] p1_n, p2_n;
    a0   = {{(c_WW-c_DW){m0[c_DW-1]}}, m0};
    a1   = {{(c_WW-c_DW){m1[c_DW-1]}}, m1};
    a2   = {{(c_WW-c_DW){m2[c_DW-1]}}, m2};
    xs   = {{(c_WW-M_bits){1'b0}}, x};
    p1   = ((a1 <<< 2) - a0 - (a0 <<< 1) - a2) >>> 1;
    p2   = (a0 - (a1 <<< 1) + a2) >>> 1;
    p1_n = p1[c_IW-1:0];
    p2_n = p2[c_IW-1:0];
    p1   = {{(c_WW-c_IW){p1_n[c_IW-1]}}, p1_n};
    p2   = {{(c_WW-c_IW){p2_n[c_IW-1]}}, p2_n};
    acc  = p1 + ((xs * p2) >>> M_bits);
    acc  = a0 + ((xs * acc) >>> M_bits);
`ifdef INTPOL2_NCH_SAT_EN
    if (acc > c_Y_MAX) begin
      acc = c_Y_MAX;
    end else if (acc < c_Y_MIN) begin
      acc = c_Y_MIN;
    end
`endif
    return acc[c_DW-1:0];
  endfunction

  // Per-channel input unpacking and interpolation
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_s_ch[gi]              = s_data[gi*c_DW +: c_DW];
      assign w_y[gi*c_DW +: c_DW]    = f_interp(r_m0[gi], r_m1[gi], r_m2[gi], r_x);
    end
  endgenerate

  assign w_cfg_bypass = config_reg[0];
  assign w_cfg_step   = config_reg[CONFIG_WIDTH +: (M_bits+1)];
  assign w_cfg_ilen   = config_reg[2*CONFIG_WIDTH +: CONFIG_WIDTH];
  // Reserved word and unused config bits are deliberately ignored.
  assign w_unused_cfg = ^config_reg;

  // Bypass is only honoured while idle and never while reset is asserted.
  assign w_bypass    = (r_state == IDLE) && w_cfg_bypass && !rst;
  assign w_m_fire    = r_m_valid && m_ready;
  assign w_out_room  = !r_m_valid || m_ready;
  assign w_more      = (r_ilen == '0) || (r_load_cnt != r_ilen);
  assign w_done_hit  = (r_ilen != '0) && (r_out_cnt == r_ilen);
  // The final output of a bounded run never requests another input sample.
  assign w_last_load = (r_ilen != '0) && ((r_load_cnt + c_CNT_ONE) == r_ilen);
  assign w_load      = (r_state == RUN) && w_out_room && w_more && !w_done_hit;
  assign w_x_sum     = {2'b00, r_x} + {1'b0, r_step};
  assign w_carry     = (w_x_sum[M_bits+1:M_bits] != 2'b00);

  // Output port steering: live pass-through in bypass, registered otherwise
  always_comb begin
    if (w_bypass) begin
      m_valid = s_valid;
      m_data  = s_data;
      s_ready = m_ready;
    end else begin
      m_valid = r_m_valid;
      m_data  = r_m_data;
      s_ready = (r_state == FILL) || (r_state == SHIFT);
    end
  end

  // Status flags derived from the controller state and handshake lines
  always_comb begin
    status_reg    = 8'h00;
    status_reg[0] = (r_state == DONE);
    status_reg[1] = (r_state == FILL) || (r_state == RUN) || (r_state == SHIFT);
    status_reg[2] = ((r_state == FILL) || (r_state == SHIFT)) && !s_valid;
    status_reg[3] = m_valid && !m_ready;
    status_reg[5] = w_bypass;
  end

  // Controller, sample window, phase accumulator and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_step     <= '0;
      r_ilen     <= '0;
      r_load_cnt <= '0;
      r_out_cnt  <= '0;
      r_x        <= '0;
      r_fill_cnt <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_m0[i] <= '0;
        r_m1[i] <= '0;
        r_m2[i] <= '0;
      end
    end else begin
      if (w_m_fire) begin
        r_out_cnt <= r_out_cnt + c_CNT_ONE;
      end

      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_y;
      end else if (w_m_fire) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (start && !w_cfg_bypass) begin
            r_step     <= (w_cfg_step == '0) ? c_STEP_FULL : w_cfg_step;
            r_ilen     <= w_cfg_ilen;
            r_load_cnt <= '0;
            r_out_cnt  <= '0;
            r_x        <= '0;
            r_fill_cnt <= '0;
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (s_valid) begin
            for (int i = 0; i < N_CH; i++) begin
              case (r_fill_cnt)
                2'd0:    r_m0[i] <= w_s_ch[i];
                2'd1:    r_m1[i] <= w_s_ch[i];
                default: r_m2[i] <= w_s_ch[i];
              endcase
            end
            if (r_fill_cnt == 2'd2) begin
              r_state <= RUN;
            end else begin
              r_fill_cnt <= r_fill_cnt + 2'd1;
            end
          end
        end
        RUN: begin
          if (w_done_hit) begin
            r_state <= DONE;
          end else if (w_load) begin
            r_load_cnt <= r_load_cnt + c_CNT_ONE;
            r_x        <= w_x_sum[M_bits-1:0];
            if (w_carry && !w_last_load) begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (s_valid) begin
            for (int i = 0; i < N_CH; i++) begin
              r_m0[i] <= r_m1[i];
              r_m1[i] <= r_m2[i];
              r_m2[i] <= w_s_ch[i];
            end
            r_state <= RUN;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
